// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller:
// state encoding, opcodes, funct codes, ALU-op classes and ALU function codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BREX    = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// selects/enables out. master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [2:0] alucontrol;
    logic       pcen;

    modport master (
        input  op, funct, zero,
        output iord, irwrite, memwrite, regwrite, regdst, memtoreg,
        output alusrca, alusrcb, pcsrc, aluop, alucontrol, pcen
    );

    modport slave (
        output op, funct, zero,
        input  iord, irwrite, memwrite, regwrite, regdst, memtoreg,
        input  alusrca, alusrcb, pcsrc, aluop, alucontrol, pcen
    );
endinterface

// File: rtl/multicycle_ctrl_aludec.sv
// aludec: combinational ALU function decode.
// Ports: aluop (class), funct (R-type field) -> alucontrol (ALU function).
module aludec
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM controller for a multicycle MIPS-style datapath.
// Ports: clk, reset (async, active-low), bus (master: op/funct/zero in, controls out).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    state_t     r_state;
    state_t     w_next;
    logic       r_bne;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic [1:0] w_aluop;

    // Branch polarity is captured in DECODE so op can change in BREX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_bne   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE)
                r_bne <= bus.op[0];
        end
    end

    always_comb begin
        w_next = FETCH;
        unique case (r_state)
            FETCH: w_next = DECODE;
            DECODE: begin
                case (bus.op)
                    LW, SW:    w_next = MEMADR;
                    RTYPE:     w_next = RTYPEEX;
                    BEQ, BNE:  w_next = BREX;
                    ADDI:      w_next = ADDIEX;
                    J:         w_next = JEX;
                    default:   w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = (bus.op == SW) ? MEMWR : MEMRD;
            MEMRD:   w_next = MEMWB;
            RTYPEEX: w_next = ALUWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_irwrite    = 1'b0;
        w_memwrite   = 1'b0;
        w_regwrite   = 1'b0;
        w_aluop      = ALUOP_ADD;
        bus.iord     = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        unique case (r_state)
            FETCH: begin
                w_irwrite   = 1'b1;
                w_pcwrite   = 1'b1;
                bus.alusrcb = 2'b01;
            end
            DECODE: bus.alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD: bus.iord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                w_regwrite   = 1'b1;
            end
            MEMWR: begin
                bus.iord   = 1'b1;
                w_memwrite = 1'b1;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                w_aluop     = ALUOP_FUNCT;
            end
            ALUWB: begin
                bus.regdst = 1'b1;
                w_regwrite = 1'b1;
            end
            ADDIWB: w_regwrite = 1'b1;
            BREX: begin
                bus.alusrca = 1'b1;
                w_aluop     = ALUOP_SUB;
                bus.pcsrc   = 2'b01;
                w_branch    = 1'b1;
            end
            JEX: begin
                bus.pcsrc = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are gated by reset so they drop without a clock edge.
    assign bus.irwrite  = reset & w_irwrite;
    assign bus.memwrite = reset & w_memwrite;
    assign bus.regwrite = reset & w_regwrite;
    assign bus.pcen     = reset &
                          (w_pcwrite | (w_branch & (bus.zero ^ r_bne)));
    assign bus.aluop    = w_aluop;

    aludec u_aludec (
        .aluop      (w_aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );
endmodule
